tick_gen: RTL
=============

Name: tick_gen

Overview:
- Programmable clock-enable pulse generator. Produces the single-cycle `i_clk_en` strobe consumed by the downstream 6-state counter and the other display-rate counters.
- Divides the system clock by a runtime-loadable divisor.
- Supports run/pause, plus single-step while paused, so the downstream sequence can be advanced manually for debug.

Parameters:
- CNT_W, 27, width of divide counter and divisor bus
- DEFAULT_DIV, 100000000, active divisor after reset (1 Hz at 100 MHz)

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_run  in  1  level; 1 = RUNNING, 0 = PAUSED
- i_step  in  1  single-cycle pulse; emits one tick while PAUSED
- i_div_load  in  1  single-cycle strobe; captures i_div_value
- i_div_value  in  CNT_W  new divisor
- o_clk_en  out  1  registered single-cycle tick to the downstream counter
- o_running  out  1  1 while FSM is in RUNNING
- o_div  out  CNT_W  currently active divisor

Behaviour:
- Reset: one clock, i_clk; reset i_rst_n is asynchronous and active-low. While asserted:
  - cnt = 0, div_act = DEFAULT_DIV, div_pend_vld = 0.
  - o_clk_en = 0, o_running = 0, o_div = DEFAULT_DIV, state = PAUSED.
  - Deassertion is sampled synchronously; no tick is produced in the first cycle after release.
- Divisor sanitise: any value of 0 or 1 is stored as 1. Divisor 1 means o_clk_en is high on every cycle while RUNNING.
- FSM states: PAUSED, RUNNING.
  - PAUSED -> RUNNING when i_run = 1.
  - RUNNING -> PAUSED when i_run = 0.
  - Transition takes effect on the edge where i_run is sampled.
- RUNNING:
  - Each edge: cnt <= (cnt == div_act-1) ? 0 : cnt+1.
  - o_clk_en <= (cnt == div_act-1).
  - Period is exactly div_act cycles. From reset release with i_run = 1, the first o_clk_en is high for the cycle following edge div_act.
- PAUSED:
  - cnt holds its value; o_clk_en <= 0, except on step.
  - i_step = 1 while PAUSED: o_clk_en = 1 for exactly one cycle, on the edge after i_step is sampled. cnt is unchanged.
  - i_step while RUNNING is ignored.
- Pause/resume: cnt is preserved, so the remaining phase continues after resume (no restart).
- Divisor load, i_div_load = 1 (sanitised value):
  - PAUSED: div_act updates immediately and cnt <= 0.
  - RUNNING: value goes to div_pend and div_pend_vld <= 1. It is applied at the next terminal count: div_act <= div_pend, cnt <= 0, div_pend_vld <= 0. That terminal-count tick still fires under the old divisor.
  - Load coinciding with terminal count: new value applied at that same edge.
  - Second load before apply: overwrites div_pend (last write wins).
- Simultaneous i_run falling and terminal count: the tick fires (registered from the current cnt), then the FSM enters PAUSED.
- div_act shrinking below cnt cannot occur, because application always resets cnt.
- o_div = div_act (registered).
- Mid-operation reset: all state returns to reset values immediately. Any pending divisor is discarded.

Optional Feature:
- Macro TICK_GEN_SYNC_EN.
- Defined:
  - i_run and i_step pass through 2-flop synchronisers; i_step is additionally rising-edge detected. Raw board button/switch levels are therefore safe.
  - Adds 2 cycles of latency on run transitions and 3 cycles from the i_step rise to o_clk_en.
  - A held i_step produces exactly one tick.
- Undefined:
  - Inputs are used directly and assumed synchronous.
  - i_step is a level sampled each cycle; holding it high while PAUSED yields a tick every cycle.

Decomposition:
- Package tick_gen_pkg:
  - state enum {ST_PAUSED, ST_RUNNING}
  - CNT_W_DEF = 27, DEFAULT_DIV_DEF = 100000000
  - sanitise function (0/1 -> 1)
- Sub-module sync_2ff: parameterised width, async active-low reset to 0. Used only under TICK_GEN_SYNC_EN.

Test Plan:
- Reset, DEFAULT_DIV overridden to 4, i_run = 1: o_clk_en high on cycles 4, 8, 12 after release; o_running = 1 from cycle 1; o_div = 4.
- i_div_value = 0 loaded while PAUSED, then run: o_div = 1 and o_clk_en stays high continuously.
- DIV = 5 running, load 3 at cnt = 1: ticks at the remaining old period (cnt 4), then every 3 cycles; o_div switches to 3 at that tick edge.
- DIV = 6: pause at cnt = 2, issue 3 step pulses, then resume: exactly 3 single-cycle ticks while PAUSED; first tick after resume arrives 4 cycles later.
- Assert i_rst_n = 0 mid-period with a pending load: o_clk_en = 0, o_div = DEFAULT_DIV immediately; the pending value is never applied.
- TICK_GEN_SYNC_EN defined, i_step held high for 10 cycles while PAUSED: exactly one tick, 3 cycles after the rise.

Source files
------------

// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen_pkg
// Description : Shared types, default parameters and the divisor sanitise
//               helper for the tick_gen clock-enable generator.
// Revision    : 1.0 - initial release
// ============================================================================
package tick_gen_pkg;

    // Run/pause control states
    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam int          CNT_W_DEF       = 27;
    localparam int unsigned DEFAULT_DIV_DEF = 100000000;

    // A divisor of 0 or 1 both mean "tick every cycle"; storing 1 keeps the
    // terminal-count compare (cnt == div - 1) from wrapping. Operates on a
    // 32-bit value so any divisor width up to 32 can share it.
    function automatic logic [31:0] sanitise_div(input logic [31:0] div);
        return (div < 32'd2) ? 32'd1 : div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Parameterised-width two-flop synchroniser with asynchronous
//               active-low reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back flops resolve metastability on asynchronous inputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Programmable clock-enable pulse generator. Divides i_clk by a
//               runtime-loadable divisor, with run/pause and single-step.
//               Optional macro TICK_GEN_SYNC_EN adds 2-flop synchronisers on
//               i_run / i_step and rising-edge detection on i_step.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_div_load,
    input  logic [CNT_W-1:0] i_div_value,
    output logic             o_clk_en,
    output logic             o_running,
    output logic [CNT_W-1:0] o_div
);

    localparam logic [CNT_W-1:0] c_default_div = CNT_W'(sanitise_div(32'(DEFAULT_DIV)));
    localparam logic [CNT_W-1:0] c_one         = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_running;
    logic             r_clk_en;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_div_pend_vld;

    logic             w_run;
    logic             w_step;
    logic             w_active;
    logic             w_term;
    logic [31:0]      w_div_san;
    logic [CNT_W-1:0] w_div_in;

`ifdef TICK_GEN_SYNC_EN
    logic [1:0] w_sync_q;
    logic       r_step_d;

    sync_2ff #(
        .WIDTH (2)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     ({i_run, i_step}),
        .o_q     (w_sync_q)
    );

    // Delayed synchronised step, so a held button yields a single pulse
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= w_sync_q[0];
        end
    end

    assign w_run  = w_sync_q[1];
    assign w_step = w_sync_q[0] & ~r_step_d;
`else
    assign w_run  = i_run;
    assign w_step = i_step;
`endif

    assign w_div_san = sanitise_div(32'(i_div_value));
    assign w_div_in  = w_div_san[CNT_W-1:0];

    // Counting happens on the edge that enters RUNNING and on the edge that
    // leaves it, so a terminal count coinciding with a pause still ticks.
    assign w_active = (r_state == ST_RUNNING) | w_run;
    assign w_term   = (r_cnt == (r_div_act - c_one));

    // Run/pause FSM, divide counter, divisor staging and tick output
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_PAUSED;
            r_running      <= 1'b0;
            r_clk_en       <= 1'b0;
            r_cnt          <= '0;
            r_div_act      <= c_default_div;
            r_div_pend     <= '0;
            r_div_pend_vld <= 1'b0;
        end else begin
            r_state   <= w_run ? ST_RUNNING : ST_PAUSED;
            r_running <= w_run;
            if (w_active) begin
                r_clk_en <= w_term;
                if (w_term) begin
                    // New divisor only lands on a period boundary
                    r_cnt          <= '0;
                    r_div_pend_vld <= 1'b0;
                    if (i_div_load) begin
                        r_div_act <= w_div_in;
                    end else if (r_div_pend_vld) begin
                        r_div_act <= r_div_pend;
                    end
                end else begin
                    r_cnt <= r_cnt + c_one;
                    if (i_div_load) begin
                        r_div_pend     <= w_div_in;
                        r_div_pend_vld <= 1'b1;
                    end
                end
            end else begin
                // Paused: phase is held, step gives a one-off tick
                r_clk_en <= w_step;
                if (i_div_load) begin
                    r_div_act      <= w_div_in;
                    r_cnt          <= '0;
                    r_div_pend_vld <= 1'b0;
                end
            end
        end
    end

    assign o_clk_en  = r_clk_en;
    assign o_running = r_running;
    assign o_div     = r_div_act;

endmodule
`default_nettype wire
